// File: rtl/router_pkg.sv
// Shared router definitions: flit width and flit type.
package router_pkg;

  localparam int unsigned FLIT_W = 16;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO for the router network interface.
// Pointers carry one extra bit so full and empty are distinguishable.
// The caller is responsible for never pushing when full without a same-cycle
// pop, and never popping when empty.
module ni_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = flit_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; a push into a full FIFO with a same-cycle pop overwrites
  // the slot whose contents are leaving through head this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/router_local_ni.sv
// Network interface between a core and the router's local port.
// TX: core flits are buffered and injected under valid/credit flow control.
// RX: ejected flits are buffered for the core; each pop returns one credit.
// Optional: define ROUTER_NI_STATS_EN to add sent/accepted flit counters.
module router_local_ni
  import router_pkg::*;
#(
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  flit_t       tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output flit_t       rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output flit_t       router_data_o,
  output logic        router_valid_o,
  input  logic        router_credit_i,
  input  flit_t       router_data_i,
  input  logic        router_valid_i,
  output logic        router_credit_o,
  output logic        rx_overflow_o
`ifdef ROUTER_NI_STATS_EN
  ,
  output logic [15:0] tx_flit_cnt_o,
  output logic [15:0] rx_flit_cnt_o
`endif
);

  localparam int unsigned   CW         = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CREDIT_ONE = 1;

  // ---------------- TX path ----------------
  flit_t         tx_head;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          send;
  logic          ready_en;
  logic [CW-1:0] credit_cnt;
  logic [CW-1:0] credit_next;

  // Holds tx_ready_o low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign tx_ready_o = ready_en && !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign send       = !tx_empty && (credit_cnt != '0);

  ni_fifo #(
    .DEPTH (TX_DEPTH),
    .T     (flit_t)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_data_i),
    .pop       (send),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Credit bookkeeping: send consumes, returned credit refills, saturating.
  always_comb begin
    credit_next = credit_cnt;
    if (send && !router_credit_i) begin
      credit_next = credit_cnt - CREDIT_ONE;
    end else if (router_credit_i && !send && (credit_cnt != CREDIT_MAX)) begin
      credit_next = credit_cnt + CREDIT_ONE;
    end
  end

  // Credit counter and registered router-side TX outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt     <= CREDIT_MAX;
      router_valid_o <= 1'b0;
      router_data_o  <= '0;
    end else begin
      credit_cnt     <= credit_next;
      router_valid_o <= send;
      router_data_o  <= send ? tx_head : '0;
    end
  end

  // ---------------- RX path ----------------
  flit_t rx_head;
  logic  rx_full;
  logic  rx_empty;
  logic  rx_push;
  logic  rx_pop;

  assign rx_pop  = !rx_empty && rx_ready_i;
  // A flit arriving while full is still accepted when the core pops the head.
  assign rx_push = router_valid_i && (!rx_full || rx_pop);

  ni_fifo #(
    .DEPTH (RX_DEPTH),
    .T     (flit_t)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (router_data_i),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign rx_valid_o = !rx_empty;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign rx_data_o  = rx_empty ? '0 : rx_head;

  // Credit return pulse per popped flit and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      router_credit_o <= 1'b0;
      rx_overflow_o   <= 1'b0;
    end else begin
      router_credit_o <= rx_pop;
      if (router_valid_i && !rx_push) rx_overflow_o <= 1'b1;
    end
  end

`ifdef ROUTER_NI_STATS_EN
  // Free-running statistics counters, wrapping modulo 2^16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_flit_cnt_o <= '0;
      rx_flit_cnt_o <= '0;
    end else begin
      if (send)    tx_flit_cnt_o <= tx_flit_cnt_o + 16'd1;
      if (rx_push) rx_flit_cnt_o <= rx_flit_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_local_ni.sv
// Directed self-checking bench for router_local_ni (CREDITS/TX/RX depth = 4).
module tb_router_local_ni;
  import router_pkg::*;

  logic  clk;
  logic  reset;
  flit_t tx_data_i;
  logic  tx_valid_i;
  logic  tx_ready_o;
  flit_t rx_data_o;
  logic  rx_valid_o;
  logic  rx_ready_i;
  flit_t router_data_o;
  logic  router_valid_o;
  logic  router_credit_i;
  flit_t router_data_i;
  logic  router_valid_i;
  logic  router_credit_o;
  logic  rx_overflow_o;
`ifdef ROUTER_NI_STATS_EN
  logic [15:0] tx_flit_cnt_o;
  logic [15:0] rx_flit_cnt_o;
`endif

  int vectors    = 0;
  int miscompares = 0;

  flit_t sent_q[$];
  int    credit_pulses = 0;

  router_local_ni #(
    .CREDITS  (4),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .router_data_o   (router_data_o),
    .router_valid_o  (router_valid_o),
    .router_credit_i (router_credit_i),
    .router_data_i   (router_data_i),
    .router_valid_i  (router_valid_i),
    .router_credit_o (router_credit_o),
    .rx_overflow_o   (rx_overflow_o)
`ifdef ROUTER_NI_STATS_EN
    ,
    .tx_flit_cnt_o   (tx_flit_cnt_o),
    .rx_flit_cnt_o   (rx_flit_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every flit on the router link and every returned credit pulse.
  always @(negedge clk) begin
    if (router_valid_o) sent_q.push_back(router_data_o);
    if (router_credit_o) credit_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_tx(input flit_t d);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    step();
    tx_valid_i = 1'b0;
  endtask

  task automatic push_rx(input flit_t d);
    router_valid_i = 1'b1;
    router_data_i  = d;
    step();
    router_valid_i = 1'b0;
  endtask

  task automatic pop_rx_expect(input string tag, input flit_t d);
    chk(tag, rx_data_o, d);
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
  endtask

  initial begin
    flit_t tmp;
    reset           = 1'b1;
    tx_data_i       = '0;
    tx_valid_i      = 1'b0;
    rx_ready_i      = 1'b0;
    router_credit_i = 1'b0;
    router_data_i   = '0;
    router_valid_i  = 1'b0;

    // ---- reset state ----
    idle(3);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_router_valid", router_valid_o, 0);
    chk("rst_router_data", router_data_o, 0);
    chk("rst_router_credit", router_credit_o, 0);
    chk("rst_overflow", rx_overflow_o, 0);
    reset = 1'b0;
    chk("rst_tx_ready_release", tx_ready_o, 0);
    step();
    chk("post_rst_tx_ready", tx_ready_o, 1);
    chk("post_rst_credit", dut.credit_cnt, 4);

    // ---- 4 flits with full credit: all sent in order ----
    push_tx(16'h1111);
    push_tx(16'h2222);
    push_tx(16'h3333);
    push_tx(16'h4444);
    idle(6);
    chk("tx4_count", sent_q.size(), 4);
    tmp = (sent_q.size() > 0) ? sent_q[0] : '0; chk("tx4_d0", tmp, 16'h1111);
    tmp = (sent_q.size() > 1) ? sent_q[1] : '0; chk("tx4_d1", tmp, 16'h2222);
    tmp = (sent_q.size() > 2) ? sent_q[2] : '0; chk("tx4_d2", tmp, 16'h3333);
    tmp = (sent_q.size() > 3) ? sent_q[3] : '0; chk("tx4_d3", tmp, 16'h4444);
    chk("tx4_credit_zero", dut.credit_cnt, 0);
    chk("tx4_valid_idle", router_valid_o, 0);

    // ---- TX fill with zero credit ----
    push_tx(16'h5555);
    push_tx(16'h6666);
    push_tx(16'h7777);
    chk("fill3_ready", tx_ready_o, 1);
    push_tx(16'h8888);
    chk("fill4_ready_low", tx_ready_o, 0);
    tx_valid_i = 1'b1;
    tx_data_i  = 16'h9999;
    idle(2);
    tx_valid_i = 1'b0;
    chk("fill5_ready_low", tx_ready_o, 0);
    chk("fill_no_send", sent_q.size(), 4);
    chk("fill_valid_low", router_valid_o, 0);

    // ---- one credit -> exactly one more flit ----
    router_credit_i = 1'b1;
    step();
    router_credit_i = 1'b0;
    step();
    chk("cred1_valid", router_valid_o, 1);
    chk("cred1_data", router_data_o, 16'h5555);
    idle(3);
    chk("cred1_count", sent_q.size(), 5);
    chk("cred1_credit", dut.credit_cnt, 0);
    chk("cred1_ready", tx_ready_o, 1);

    // ---- send and credit in the same cycle ----
    router_credit_i = 1'b1;
    step();
    chk("simul_pre_credit", dut.credit_cnt, 1);
    step();
    chk("simul_credit_hold", dut.credit_cnt, 1);
    chk("simul_valid", router_valid_o, 1);
    chk("simul_data", router_data_o, 16'h6666);
    router_credit_i = 1'b0;
    step();
    chk("simul_next_data", router_data_o, 16'h7777);
    chk("simul_next_credit", dut.credit_cnt, 0);
    step();
    chk("simul_valid_drop", router_valid_o, 0);

    // ---- refill credits past the maximum: saturates at 4 ----
    router_credit_i = 1'b1;
    idle(6);
    router_credit_i = 1'b0;
    chk("sat_credit", dut.credit_cnt, 4);
    idle(2);
    chk("sat_count", sent_q.size(), 8);
    tmp = (sent_q.size() > 7) ? sent_q[7] : '0; chk("sat_last", tmp, 16'h8888);
    chk("sat_credit_idle", dut.credit_cnt, 4);

    // ---- RX pop timing ----
    push_rx(16'hABCD);
    chk("rx_valid", rx_valid_o, 1);
    chk("rx_data", rx_data_o, 16'hABCD);
    chk("rx_no_credit_yet", router_credit_o, 0);
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    chk("rx_popped_empty", rx_valid_o, 0);
    chk("rx_credit_pulse", router_credit_o, 1);
    step();
    chk("rx_credit_single", router_credit_o, 0);
    chk("rx_credit_count", credit_pulses, 1);

    // ---- RX push and pop while full ----
    push_rx(16'hB001);
    push_rx(16'hB002);
    push_rx(16'hB003);
    push_rx(16'hB004);
    chk("full_head", rx_data_o, 16'hB001);
    router_valid_i = 1'b1;
    router_data_i  = 16'hB005;
    rx_ready_i     = 1'b1;
    step();
    router_valid_i = 1'b0;
    rx_ready_i     = 1'b0;
    chk("full_pp_overflow", rx_overflow_o, 0);
    chk("full_pp_valid", rx_valid_o, 1);
    pop_rx_expect("full_pp_d1", 16'hB002);
    pop_rx_expect("full_pp_d2", 16'hB003);
    pop_rx_expect("full_pp_d3", 16'hB004);
    pop_rx_expect("full_pp_d4", 16'hB005);
    chk("full_pp_empty", rx_valid_o, 0);
    idle(2);
    chk("full_pp_credits", credit_pulses, 6);

    // ---- RX overflow ----
    push_rx(16'hA001);
    push_rx(16'hA002);
    push_rx(16'hA003);
    push_rx(16'hA004);
    chk("ovf_before", rx_overflow_o, 0);
    push_rx(16'hA005);
    chk("ovf_set", rx_overflow_o, 1);
    idle(2);
    chk("ovf_sticky", rx_overflow_o, 1);
    pop_rx_expect("ovf_d0", 16'hA001);
    pop_rx_expect("ovf_d1", 16'hA002);
    pop_rx_expect("ovf_d2", 16'hA003);
    pop_rx_expect("ovf_d3", 16'hA004);
    chk("ovf_drained", rx_valid_o, 0);
    chk("ovf_still_set", rx_overflow_o, 1);
    idle(2);
    chk("ovf_credits", credit_pulses, 10);

    // ---- reset mid-transfer ----
    push_tx(16'hC001);
    push_tx(16'hC002);
    push_tx(16'hC003);
    push_tx(16'hC004);
    push_tx(16'hD001);
    push_tx(16'hD002);
    push_tx(16'hD003);
    push_rx(16'hE001);
    push_rx(16'hE002);
    push_rx(16'hE003);
    idle(3);
    chk("mid_sent", sent_q.size(), 12);
    chk("mid_credit_zero", dut.credit_cnt, 0);
    chk("mid_rx_valid", rx_valid_o, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_ready", tx_ready_o, 0);
    chk("mid_rst_rx_valid", rx_valid_o, 0);
    chk("mid_rst_rx_data", rx_data_o, 0);
    chk("mid_rst_router_valid", router_valid_o, 0);
    chk("mid_rst_router_data", router_data_o, 0);
    chk("mid_rst_router_credit", router_credit_o, 0);
    chk("mid_rst_overflow", rx_overflow_o, 0);
    chk("mid_rst_credit", dut.credit_cnt, 4);
    idle(2);
    reset = 1'b0;
    step();
    chk("mid_post_tx_ready", tx_ready_o, 1);
    idle(4);
    chk("mid_post_no_send", sent_q.size(), 12);
    chk("mid_post_no_credit", credit_pulses, 10);
    chk("mid_post_rx_empty", rx_valid_o, 0);
    chk("mid_post_credit", dut.credit_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the directed sequence is short, so a stall means a broken run.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
